// File: rtl/async_fifo_wr_feeder.sv
// Write-domain message serializer for the async FIFO write port.
// Accepts a message over valid/ready, pushes its bytes LSB first, and
// inserts one idle cycle after every push so that the FIFO's registered
// full flag is always up to date before the next write.
module async_fifo_wr_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int MSG_BYTES  = 4,
  parameter int LEN_WIDTH  = 3
) (
  input  logic                            w_clk,
  input  logic                            wrst_n,
  input  logic                            msg_valid,
  input  logic [MSG_BYTES*DATA_WIDTH-1:0] msg_data,
  input  logic [LEN_WIDTH-1:0]            msg_len,
  output logic                            msg_ready,
  input  logic                            wfull,
  output logic                            w_inc,
  output logic [DATA_WIDTH-1:0]           w_data,
  output logic                            busy,
  output logic                            done
);

  localparam int MSG_WIDTH = MSG_BYTES * DATA_WIDTH;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MSG_BYTES);
  localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [MSG_WIDTH-1:0]   shift_q, shift_d;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic                   gap_q, gap_d;
  logic [LEN_WIDTH-1:0]   len_clamped;

  // Oversized lengths are clamped to the payload size.
  assign len_clamped = (msg_len > MAX_LEN) ? MAX_LEN : msg_len;

  // Status outputs decode straight from the state register.
  assign msg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign w_data    = shift_q[DATA_WIDTH-1:0];

  // Next-state logic plus the combinational write strobe.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    state_d     = state_q;
    shift_d     = shift_q;
    remaining_d = remaining_q;
    gap_d       = gap_q;
    w_inc       = 1'b0;

    case (state_q)
      IDLE: begin
        if (msg_valid) begin
          shift_d     = msg_data;
          remaining_d = len_clamped;
          gap_d       = 1'b0;
          state_d     = (len_clamped != '0) ? PUSH : DONE;
        end
      end

      PUSH: begin
        if (!wfull && !gap_q) begin
          // The FIFO samples w_inc on this same edge, so the entry is taken now.
          w_inc   = 1'b1;
          shift_d = shift_q >> DATA_WIDTH;
          gap_d   = 1'b1;
          if (remaining_q != '0) begin
            remaining_d = remaining_q - ONE;
          end
          if (remaining_q == ONE) begin
            state_d = DONE;
          end
        end else begin
          // A non-push cycle lets the full flag catch up with the last write.
          gap_d = 1'b0;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge w_clk or negedge wrst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    if (!wrst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      remaining_q <= '0;
      gap_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_feeder.sv
// Self-checking bench for async_fifo_wr_feeder. Expected push cycles come
// from a timing model: the next byte goes out in the first cycle that is at
// least two cycles after the previous push and has wfull low.
module tb_async_fifo_wr_feeder;

  logic        w_clk = 1'b0;
  logic        wrst_n;
  logic        msg_valid;
  logic [31:0] msg_data;
  logic [2:0]  msg_len;
  logic        msg_ready;
  logic        wfull;
  logic        w_inc;
  logic [7:0]  w_data;
  logic        busy;
  logic        done;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int last_inc = -10;

  async_fifo_wr_feeder #(
    .DATA_WIDTH(8),
    .MSG_BYTES (4),
    .LEN_WIDTH (3)
  ) dut (
    .w_clk    (w_clk),
    .wrst_n   (wrst_n),
    .msg_valid(msg_valid),
    .msg_data (msg_data),
    .msg_len  (msg_len),
    .msg_ready(msg_ready),
    .wfull    (wfull),
    .w_inc    (w_inc),
    .w_data   (w_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 w_clk = ~w_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Outputs expected whenever the block sits idle or in reset.
  task automatic check_idle(input string tag);
    check({tag, " w_inc"}, 32'(w_inc), 32'd0);
    check({tag, " msg_ready"}, 32'(msg_ready), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge w_clk);
      msg_valid = 1'b0;
      wfull     = 1'($urandom);
      #1;
      check_idle("idle");
      @(posedge w_clk);
      cyc++;
    end
  endtask

  // Send one message starting in the current cycle (c0). fmask[i] is wfull
  // in cycle ci. hold_valid keeps msg_valid high with junk while busy.
  // rst_at >= 0 asserts reset in that cycle and aborts the message.
  task automatic send(input logic [31:0] data, input logic [2:0] len,
                      input logic [63:0] fmask, input bit hold_valid,
                      input int rst_at);
    int n, t, k, done_c, seen;
    int push_at [4];
    logic [7:0] bytes [4];
    bit exp_inc;

    n = (len > 3'd4) ? 4 : int'(len);
    t = 1;
    for (int j = 0; j < n; j++) begin
      while (fmask[t] && t < 63) t++;
      push_at[j] = t;
      t += 2;
    end
    done_c = (n == 0) ? 1 : push_at[n-1] + 1;
    for (int j = 0; j < 4; j++) bytes[j] = data[8*j +: 8];

    k    = 0;
    seen = 0;
    for (int i = 0; i <= done_c; i++) begin
      @(negedge w_clk);
      wfull     = (i == 0) ? 1'b0 : fmask[i];
      msg_valid = (i == 0) || hold_valid;
      msg_data  = (i == 0) ? data : $urandom;
      msg_len   = (i == 0) ? len : 3'($urandom);
      if (i == rst_at) begin
        wrst_n = 1'b0;
        #1;
        check_idle("rst_mid");
        check("rst_mid w_data", 32'(w_data), 32'd0);
        msg_valid = 1'b0;
        for (int r = 0; r < 2; r++) begin
          @(negedge w_clk);
          check_idle("rst_hold");
          cyc++;
        end
        wrst_n   = 1'b1;
        last_inc = -10;
        @(posedge w_clk);
        cyc++;
        return;
      end
      #1;
      exp_inc = (k < n) && (push_at[k] == i);
      check("msg_ready", 32'(msg_ready), 32'(i == 0));
      check("busy", 32'(busy), 32'(i != 0));
      check("done", 32'(done), 32'(i == done_c));
      check("w_inc", 32'(w_inc), 32'(exp_inc));
      if (i >= 1 && k < n) check("w_data", 32'(w_data), 32'(bytes[k]));
      if (w_inc === 1'b1) begin
        check("gap", 32'((cyc - last_inc) >= 2), 32'd1);
        last_inc = cyc;
        seen++;
      end
      if (exp_inc) k++;
      @(posedge w_clk);
      cyc++;
    end
    check("push_count", 32'(seen), 32'(n));
    if (!hold_valid) msg_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] fm;

    // Reset held with a message on offer: nothing may be accepted.
    wrst_n    = 1'b0;
    msg_valid = 1'b1;
    msg_data  = 32'hCAFEF00D;
    msg_len   = 3'd4;
    wfull     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge w_clk);
      check_idle("reset");
      check("reset w_data", 32'(w_data), 32'd0);
    end
    msg_valid = 1'b0;
    wrst_n    = 1'b1;
    @(posedge w_clk);
    cyc++;
    idle(2);

    // Basic 4-byte message, no backpressure.
    send(32'hDDCCBBAA, 3'd4, 64'd0, 1'b0, -1);
    idle(1);

    // wfull high in c3..c6.
    send(32'hDDCCBBAA, 3'd4, 64'h78, 1'b0, -1);
    idle(1);

    // Length edges: zero, clamped, single byte.
    send(32'h01020304, 3'd0, 64'd0, 1'b0, -1);
    send(32'h89ABCDEF, 3'd7, 64'd0, 1'b0, -1);
    send(32'h0000005A, 3'd1, 64'd0, 1'b0, -1);
    idle(1);

    // wfull dropping right after a push is honoured one cycle late.
    send(32'h44332211, 3'd3, 64'h4, 1'b0, -1);

    // Reset in c4, after the second push; then a fresh 2-byte message.
    send(32'hDDCCBBAA, 3'd4, 64'd0, 1'b0, 4);
    idle(1);
    send(32'h00001234, 3'd2, 64'd0, 1'b0, -1);

    // Back-to-back: valid held during busy with changing data.
    send(32'h11223344, 3'd3, 64'd0, 1'b1, -1);
    send(32'h55667788, 3'd2, 64'h8, 1'b1, -1);
    send(32'h99AABBCC, 3'd4, 64'd0, 1'b0, -1);
    idle(1);

    // Randomized messages with random backpressure.
    for (int m = 0; m < 25; m++) begin
      fm = '0;
      for (int b = 1; b < 40; b++) fm[b] = ($urandom_range(0, 2) == 0);
      send($urandom, 3'($urandom_range(0, 7)), fm, 1'($urandom), -1);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_fifo_wr_feeder.md
Name: async_fifo_wr_feeder

Overview:
- Write-domain initiator for the async FIFO write port.
- Accepts a multi-byte message from a w_clk-domain producer (SYS_CTRL / ALU result path) over a valid/ready handshake.
- Serializes the message LSB byte first and drives w_inc/w_data into the FIFO write side, obeying wfull.
- Paces pushes so the write side's one-cycle-late full flag can never cause an overflow.

Parameters:
- DATA_WIDTH, 8: width of one FIFO entry / message byte.
- MSG_BYTES, 4: maximum bytes per message.
- LEN_WIDTH, 3: width of msg_len; must hold the value MSG_BYTES.

Ports:
- w_clk  input  1  write-domain clock.
- wrst_n  input  1  reset.
- msg_valid  input  1  producer presents a message.
- msg_data  input  MSG_BYTES*DATA_WIDTH  message payload; byte 0 = bits [DATA_WIDTH-1:0].
- msg_len  input  LEN_WIDTH  number of bytes to send.
- msg_ready  output  1  feeder can accept a message.
- wfull  input  1  FIFO full flag from the write side.
- w_inc  output  1  FIFO write strobe; one entry is written per cycle it is high.
- w_data  output  DATA_WIDTH  FIFO write data.
- busy  output  1  message in progress.
- done  output  1  one-cycle pulse when the message is fully pushed.

Behaviour:
- Clock and reset: clock w_clk; reset wrst_n, asynchronous, active-low.
- Reset values: state IDLE; msg_ready=1, w_inc=0, w_data=0, busy=0, done=0; shift register, byte counter and gap flag all 0.
- FSM states: IDLE, PUSH, DONE. busy = (state != IDLE). msg_ready = (state == IDLE).
- IDLE, on msg_valid && msg_ready (cycle c0):
  - Register msg_data into the shift register.
  - Load remaining = min(msg_len, MSG_BYTES); msg_len > MSG_BYTES is clamped.
  - Clear the gap flag.
  - Next state is PUSH if remaining != 0, otherwise DONE.
- PUSH:
  - w_data = low DATA_WIDTH bits of the shift register (registered, stable while stalled).
  - w_inc = (state==PUSH) && !wfull && !gap. This is combinational so the FIFO samples it in the same cycle.
  - On a cycle with w_inc=1: shift right by DATA_WIDTH (zero fill), decrement remaining, set gap=1.
  - On a cycle with w_inc=0: clear gap.
  - Result: at most one push per 2 cycles, which covers the write side's registered gray-pointer/full latency.
  - When remaining reaches 0 after a push, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- msg_valid is ignored while busy. Inputs are sampled only at acceptance, so msg_data and msg_len may change afterwards.
- Timing, len=N, wfull=0 throughout:
  - w_inc in cycles c1, c3, …, c(2N-1).
  - done in c(2N).
  - msg_ready=1 again in c(2N+1).
  - len=0: done in c1, no w_inc.
- wfull=1 in PUSH:
  - w_inc=0 and state is held indefinitely; w_data, remaining and shift register are unchanged.
  - The push occurs in the first cycle wfull=0 with gap=0.
  - A wfull deassertion in the cycle right after a push is honoured one cycle later, because gap is still set.
- Reset mid-message: all state returns to reset values asynchronously and w_inc drops immediately. Bytes already pushed stay in the FIFO; there is no rollback.
- Counter width: remaining uses LEN_WIDTH bits and never underflows, because a decrement happens only when remaining != 0.

Test Plan:
- Reset: hold wrst_n=0 with msg_valid=1 -> msg_ready=1, w_inc=0, w_data=0, busy=0, done=0; nothing accepted during reset.
- Basic message: msg_len=4, msg_data=0xDDCCBBAA, wfull=0 -> w_inc high in c1/c3/c5/c7 with w_data 0xAA/0xBB/0xCC/0xDD; done pulses in c8; msg_ready=1 in c9; exactly 4 writes.
- Backpressure: same message with wfull=1 during c3..c6 -> bytes 0xAA in c1 and 0xBB in c7, no w_inc in c2..c6, w_data=0xBB held through the stall; remaining bytes in c9/c11; done in c12.
- Length edges: msg_len=0 -> done in c1, no w_inc. msg_len=7 -> clamped, exactly 4 pushes. msg_len=1, data 0x5A -> single push of 0x5A in c1, done in c2.
- Reset mid-operation: assert wrst_n=0 after the second push of a 4-byte message -> w_inc=0 at once and no further pushes; after release, msg_ready=1 and a new 2-byte message 0x1234 pushes 0x34 then 0x12.
- Back-to-back: msg_valid held high with changing data during busy -> the second message is accepted only in the IDLE cycle after done, and its bytes follow with no gap violation (≥1 idle cycle between any two w_inc).
